// File: rtl/gray_conv_pkg.sv
// Shared definitions for the binary/Gray stream converter.
// Conversion helpers work on a GRAY_MAX_W-wide vector. Callers zero-extend
// their word before the call and truncate the result afterwards. Zero
// extension does not change either conversion in the low bits, so one pair
// of functions covers every WIDTH up to GRAY_MAX_W.
package gray_conv_pkg;

  localparam logic MODE_B2G = 1'b0;
  localparam logic MODE_G2B = 1'b1;

  localparam int GRAY_MAX_W = 64;

  // Per-word side information that travels alongside the converted data.
  typedef struct packed {
    logic mode;
    logic step_err;
  } gray_tag_t;

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_conv_skid.sv
// Generic 2-entry output/skid register for a valid/ready stream.
// OUT drives the consumer. SKID catches the one word that can arrive while
// OUT is stalled. in_ready comes straight from a flop, so the upstream ready
// path never depends combinationally on out_ready.
module gray_conv_skid #(
  parameter int PW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_payload,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_payload
);

  logic          outValid_q, outValid_d;
  logic [PW-1:0] outPayload_q, outPayload_d;
  logic          skidValid_q, skidValid_d;
  logic [PW-1:0] skidPayload_q, skidPayload_d;
  logic          accept;
  logic          outFree;

  assign in_ready    = !skidValid_q;
  assign accept      = in_valid && !skidValid_q;
  assign outFree     = !outValid_q || out_ready;
  assign out_valid   = outValid_q;
  assign out_payload = outPayload_q;

  // Next-state: drain SKID first to keep order, else load OUT, else park in SKID.
  always_comb begin
    outValid_d    = outValid_q;
    outPayload_d  = outPayload_q;
    skidValid_d   = skidValid_q;
    skidPayload_d = skidPayload_q;
    if (outFree) begin
      if (skidValid_q) begin
        outValid_d   = 1'b1;
        outPayload_d = skidPayload_q;
        skidValid_d  = 1'b0;
      end else if (accept) begin
        outValid_d   = 1'b1;
        outPayload_d = in_payload;
      end else begin
        outValid_d   = 1'b0;
      end
    end else if (accept) begin
      skidValid_d   = 1'b1;
      skidPayload_d = in_payload;
    end
  end

  // State registers; reset discards both stored words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outValid_q    <= 1'b0;
      outPayload_q  <= '0;
      skidValid_q   <= 1'b0;
      skidPayload_q <= '0;
    end else begin
      outValid_q    <= outValid_d;
      outPayload_q  <= outPayload_d;
      skidValid_q   <= skidValid_d;
      skidPayload_q <= skidPayload_d;
    end
  end

endmodule

// File: rtl/gray_code_conv.sv
// Bidirectional binary/Gray converter with a registered valid/ready stream.
// Conversion happens combinationally on the input side. Only the converted
// word, its mode and its step-error flag are stored in the skid stage.
// Optional feature macro: GRAY_CONV_STEP_CHECK_EN. When it is defined, every
// accepted Gray->binary word is compared with the previous one and flagged
// unless exactly one bit changed. WIDTH must not exceed GRAY_MAX_W.
module gray_code_conv
  import gray_conv_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_mode,
  output logic             out_step_err
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    gray_tag_t        tag;
  } entry_t;

  logic             accept;
  logic [WIDTH-1:0] b2gData;
  logic [WIDTH-1:0] g2bData;
  logic [WIDTH-1:0] convData;
  logic             stepErr;
  entry_t           inEntry;
  entry_t           outEntry;

  assign accept   = in_valid && in_ready;
  assign b2gData  = WIDTH'(bin2gray(GRAY_MAX_W'(in_data)));
  assign g2bData  = WIDTH'(gray2bin(GRAY_MAX_W'(in_data)));
  assign convData = (in_mode == MODE_G2B) ? g2bData : b2gData;

`ifdef GRAY_CONV_STEP_CHECK_EN
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             havePrev_q, havePrev_d;
  logic [WIDTH-1:0] stepDiff;

  assign stepDiff = in_data ^ prev_q;

  // Flag a Gray word whose distance from the previous Gray word is not exactly one bit.
  always_comb begin
    stepErr = 1'b0;
    if (havePrev_q && (in_mode == MODE_G2B)) begin
      stepErr = !((stepDiff != '0) && ((stepDiff & (stepDiff - WIDTH'(1))) == '0));
    end
  end

  // Only accepted Gray->binary words advance the history.
  always_comb begin
    prev_d     = prev_q;
    havePrev_d = havePrev_q;
    if (accept && (in_mode == MODE_G2B)) begin
      prev_d     = in_data;
      havePrev_d = 1'b1;
    end
  end

  // History registers, cleared so the first Gray word after reset is never flagged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q     <= '0;
      havePrev_q <= 1'b0;
    end else begin
      prev_q     <= prev_d;
      havePrev_q <= havePrev_d;
    end
  end
`else
  assign stepErr = 1'b0;
`endif

  // Pack the converted word with its side information for storage.
  always_comb begin
    inEntry              = '0;
    inEntry.data         = convData;
    inEntry.tag.mode     = in_mode;
    inEntry.tag.step_err = stepErr;
  end

  gray_conv_skid #(
    .PW($bits(entry_t))
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_payload (inEntry),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_payload(outEntry)
  );

  assign out_data     = outEntry.data;
  assign out_mode     = outEntry.tag.mode;
  assign out_step_err = outEntry.tag.step_err;

endmodule

// File: tb/tb_gray_code_conv.sv
// Directed self-checking bench for gray_code_conv (WIDTH 8 and WIDTH 4 instances).
// Step-error expectations follow GRAY_CONV_STEP_CHECK_EN when it is defined for the build.
module tb_gray_code_conv;

  logic       clk;
  logic       rst;
  logic       inValid;
  logic       inReady;
  logic [7:0] inData;
  logic       inMode;
  logic       outValid;
  logic       outReady;
  logic [7:0] outData;
  logic       outMode;
  logic       outStepErr;

  logic       inValid4;
  logic       inReady4;
  logic [3:0] inData4;
  logic       inMode4;
  logic       outValid4;
  logic       outReady4;
  logic [3:0] outData4;
  logic       outMode4;
  logic       outStepErr4;

  int passCount = 0;
  int checkCount = 0;

  gray_code_conv #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (inValid),
    .in_ready    (inReady),
    .in_data     (inData),
    .in_mode     (inMode),
    .out_valid   (outValid),
    .out_ready   (outReady),
    .out_data    (outData),
    .out_mode    (outMode),
    .out_step_err(outStepErr)
  );

  gray_code_conv #(.WIDTH(4)) dut4 (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (inValid4),
    .in_ready    (inReady4),
    .in_data     (inData4),
    .in_mode     (inMode4),
    .out_valid   (outValid4),
    .out_ready   (outReady4),
    .out_data    (outData4),
    .out_mode    (outMode4),
    .out_step_err(outStepErr4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] modelB2g(input logic [7:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [7:0] modelG2b(input logic [7:0] g);
    logic [7:0] r;
    r = g;
    for (int s = 1; s < 8; s++) r = r ^ (g >> s);
    return r;
  endfunction

  // Present one word for a single cycle; the caller ensures SKID is empty.
  task automatic pushWord(input logic [7:0] d, input logic m);
    inValid = 1'b1;
    inData  = d;
    inMode  = m;
    @(posedge clk); #1;
    inValid = 1'b0;
  endtask

  task automatic pushWord4(input logic [3:0] d, input logic m);
    inValid4 = 1'b1;
    inData4  = d;
    inMode4  = m;
    @(posedge clk); #1;
    inValid4 = 1'b0;
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkCount++;
    if (outValid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b expected 0", outValid);
    else passCount++;
    checkCount++;
    if (inReady !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b expected 1", inReady);
    else passCount++;
    checkCount++;
    if (outData !== 8'h00 || outMode !== 1'b0 || outStepErr !== 1'b0)
      $display("[TB] FAIL reset_out_regs: got data %h mode %b err %b expected 00 0 0", outData, outMode, outStepErr);
    else passCount++;
    rst = 1'b0;
    inData = 8'hAA;
    inMode = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkCount++;
    if (outValid !== 1'b0) $display("[TB] FAIL idle_ignores_data: got out_valid %b expected 0", outValid);
    else passCount++;
  endtask

  task automatic test_directed();
    outReady = 1'b1;
    pushWord(8'h05, 1'b0);
    checkCount++;
    if (outValid !== 1'b1 || outData !== 8'h07 || outMode !== 1'b0)
      $display("[TB] FAIL b2g_05: got v%b %h m%b expected v1 07 m0", outValid, outData, outMode);
    else passCount++;
    pushWord(8'h80, 1'b1);
    checkCount++;
    if (outValid !== 1'b1 || outData !== 8'hFF || outMode !== 1'b1)
      $display("[TB] FAIL g2b_80: got v%b %h m%b expected v1 FF m1", outValid, outData, outMode);
    else passCount++;
    pushWord(8'hFF, 1'b0);
    checkCount++;
    if (outValid !== 1'b1 || outData !== 8'h80 || outMode !== 1'b0)
      $display("[TB] FAIL b2g_FF: got v%b %h m%b expected v1 80 m0", outValid, outData, outMode);
    else passCount++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [8];
    logic [7:0] expData [8];
    logic       expMode [8];
    int         tx;
    int         rx;
    logic       accepted;
    words = '{8'h00, 8'h01, 8'h3C, 8'hFF, 8'h80, 8'h5A, 8'hC3, 8'h7E};
    for (int i = 0; i < 8; i++) begin
      expMode[i] = i[0];
      expData[i] = i[0] ? modelG2b(words[i]) : modelB2g(words[i]);
    end
    @(posedge clk); #1;
    outReady = 1'b0;
    inValid  = 1'b1;
    inData   = words[0];
    inMode   = expMode[0];
    @(posedge clk); #1;
    checkCount++;
    if (inReady !== 1'b1) $display("[TB] FAIL stall_ready_after_1: got %b expected 1", inReady);
    else passCount++;
    inData = words[1];
    inMode = expMode[1];
    @(posedge clk); #1;
    checkCount++;
    if (inReady !== 1'b0) $display("[TB] FAIL stall_ready_after_2: got %b expected 0", inReady);
    else passCount++;
    inData = words[2];
    inMode = expMode[2];
    for (int c = 0; c < 3; c++) begin
      checkCount++;
      if (outValid !== 1'b1 || outData !== expData[0] || outMode !== expMode[0] || inReady !== 1'b0)
        $display("[TB] FAIL stall_hold: got v%b %h m%b rdy%b expected v1 %h m%b rdy0",
                 outValid, outData, outMode, inReady, expData[0], expMode[0]);
      else passCount++;
      @(posedge clk); #1;
    end
    outReady = 1'b1;
    tx = 2;
    rx = 0;
    for (int c = 0; c < 40 && rx < 8; c++) begin
      if (outValid === 1'b1) begin
        checkCount++;
        if (outData !== expData[rx] || outMode !== expMode[rx])
          $display("[TB] FAIL stream_word%0d: got %h m%b expected %h m%b", rx, outData, outMode, expData[rx], expMode[rx]);
        else passCount++;
        rx++;
      end
      accepted = inValid && inReady;
      @(posedge clk); #1;
      if (accepted) begin
        tx++;
        if (tx < 8) begin
          inData = words[tx];
          inMode = expMode[tx];
        end else begin
          inValid = 1'b0;
        end
      end
    end
    checkCount++;
    if (rx !== 8) $display("[TB] FAIL stream_count: got %0d words expected 8", rx);
    else passCount++;
    inValid = 1'b0;
    @(posedge clk); #1;
    checkCount++;
    if (outValid !== 1'b0) $display("[TB] FAIL stream_no_extra: got out_valid %b expected 0", outValid);
    else passCount++;
  endtask

  task automatic test_reset_mid();
    outReady = 1'b0;
    pushWord(8'h11, 1'b0);
    pushWord(8'h22, 1'b1);
    checkCount++;
    if (inReady !== 1'b0 || outValid !== 1'b1)
      $display("[TB] FAIL mid_full: got rdy%b v%b expected rdy0 v1", inReady, outValid);
    else passCount++;
    #2 rst = 1'b1;
    #1;
    checkCount++;
    if (outValid !== 1'b0 || inReady !== 1'b1)
      $display("[TB] FAIL mid_reset_async: got v%b rdy%b expected v0 rdy1", outValid, inReady);
    else passCount++;
    @(posedge clk); #1;
    rst = 1'b0;
    outReady = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checkCount++;
      if (outValid !== 1'b0) $display("[TB] FAIL mid_no_ghost: got out_valid %b expected 0", outValid);
      else passCount++;
    end
    pushWord(8'h05, 1'b0);
    checkCount++;
    if (outValid !== 1'b1 || outData !== 8'h07)
      $display("[TB] FAIL mid_first_after: got v%b %h expected v1 07", outValid, outData);
    else passCount++;
  endtask

  task automatic test_step_check();
    logic [7:0] stepIn   [5];
    logic       stepMode [5];
    logic [7:0] stepOut  [5];
    logic       stepErr  [5];
    logic       lastErr;
`ifdef GRAY_CONV_STEP_CHECK_EN
    lastErr = 1'b1;
`else
    lastErr = 1'b0;
`endif
    stepIn   = '{8'h00, 8'h01, 8'h03, 8'h55, 8'h00};
    stepMode = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    stepOut  = '{8'h00, 8'h01, 8'h02, 8'h7F, 8'h00};
    stepErr  = '{1'b0, 1'b0, 1'b0, 1'b0, lastErr};
    pulseReset();
    outReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pushWord(stepIn[i], stepMode[i]);
      checkCount++;
      if (outValid !== 1'b1 || outData !== stepOut[i] || outStepErr !== stepErr[i])
        $display("[TB] FAIL step%0d: got v%b %h err%b expected v1 %h err%b",
                 i, outValid, outData, outStepErr, stepOut[i], stepErr[i]);
      else passCount++;
    end
  endtask

  task automatic test_sweep8();
    logic [7:0] xv;
    outReady = 1'b1;
    for (int x = 0; x < 256; x++) begin
      xv = 8'(x);
      pushWord(xv, 1'b0);
      checkCount++;
      if (outValid !== 1'b1 || outData !== modelB2g(xv) || outMode !== 1'b0)
        $display("[TB] FAIL sweep8_b2g %h: got v%b %h expected v1 %h", xv, outValid, outData, modelB2g(xv));
      else passCount++;
      pushWord(modelB2g(xv), 1'b1);
      checkCount++;
      if (outValid !== 1'b1 || outData !== xv || outMode !== 1'b1)
        $display("[TB] FAIL sweep8_roundtrip %h: got v%b %h expected v1 %h", xv, outValid, outData, xv);
      else passCount++;
    end
  endtask

  task automatic test_sweep4();
    logic [3:0] xv;
    logic [3:0] gv;
    outReady4 = 1'b1;
    for (int x = 0; x < 16; x++) begin
      xv = 4'(x);
      gv = xv ^ (xv >> 1);
      pushWord4(xv, 1'b0);
      checkCount++;
      if (outValid4 !== 1'b1 || outData4 !== gv)
        $display("[TB] FAIL sweep4_b2g %h: got v%b %h expected v1 %h", xv, outValid4, outData4, gv);
      else passCount++;
      pushWord4(gv, 1'b1);
      checkCount++;
      if (outValid4 !== 1'b1 || outData4 !== xv || outMode4 !== 1'b1)
        $display("[TB] FAIL sweep4_roundtrip %h: got v%b %h expected v1 %h", xv, outValid4, outData4, xv);
      else passCount++;
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    rst       = 1'b1;
    inValid   = 1'b0;
    inData    = 8'h00;
    inMode    = 1'b0;
    outReady  = 1'b0;
    inValid4  = 1'b0;
    inData4   = 4'h0;
    inMode4   = 1'b0;
    outReady4 = 1'b1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid();
    test_step_check();
    test_sweep8();
    test_sweep4();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
